// File: rtl/pll_reset_ctrl_pkg.sv
// Shared definitions for the PLL reset/power sequencer: state encodings and
// a width helper used to size counters and ports.
package pll_reset_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_RESET     = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_RELEASE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd5;
    localparam logic [STATE_W-1:0] ST_FAULT     = 3'd6;

    // Ceiling log2, never below 1 so the result can always size a vector.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; only sync_q is safe to use downstream.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset/power sequencer. Pulses PLL RST, waits for a debounced lock with
// a per-attempt timeout and bounded retries, then releases downstream resets
// one stage at a time. Lock loss after release restarts the sequence.
// Handshake note: there is no valid/ready traffic here; EN is a level request
// and READY is a level status that is only high while all stages are released
// and lock is held.
module pll_reset_ctrl
    import pll_reset_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 1000,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int NUM_STAGES          = 3,
    parameter int STAGE_DELAY_CYCLES  = 4,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                            CLK,
    input  logic                            RSTN,
    input  logic                            EN,
    input  logic                            LOCKED,
    output logic                            PLL_RST,
    output logic                            PLL_PWRDWN,
    output logic [NUM_STAGES-1:0]           RST_OUT_N,
    output logic                            READY,
    output logic                            FAULT,
    output logic [clog2(MAX_RETRIES+1)-1:0] RETRY_CNT,
    output logic [STATE_W-1:0]              DBG_STATE
);

    localparam int RC_W      = clog2(MAX_RETRIES + 1);
    localparam int TMO_W     = clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int STG_W     = clog2(NUM_STAGES + 1);
    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                               RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > STAGE_DELAY_CYCLES) ?
                               CNT_MAX_A : STAGE_DELAY_CYCLES;
    localparam int CNT_W     = clog2(CNT_MAX + 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [STG_W-1:0]      stg_q, stg_d;
    logic [RC_W-1:0]       retry_q, retry_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  pll_rst_q, pll_rst_d;
    logic                  pwrdwn_q, pwrdwn_d;
    logic                  ready_q, ready_d;
    logic                  fault_q, fault_d;
    logic                  lk;
    logic                  timeout;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .d_i    (LOCKED),
        .q_o    (lk)
    );

    // Next state, counters and registered outputs (outputs follow next state).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        stg_d     = stg_q;
        retry_d   = retry_q;
        rst_out_d = rst_out_q;
        pll_rst_d = 1'b0;
        pwrdwn_d  = 1'b0;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        timeout   = (tmo_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1));

        if (!EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RESET;
                ST_RESET: begin
                    // The lock timeout restarts with every new attempt.
                    tmo_d = '0;
                    if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) state_d = ST_WAIT_LOCK;
                    else                                        cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    if (timeout) begin
                        if ((int'(retry_q) + 1) < MAX_RETRIES) begin
                            state_d = ST_RESET;
                            retry_d = retry_q + RC_W'(1);
                        end else begin
                            state_d = ST_FAULT;
                            retry_d = RC_W'(MAX_RETRIES);
                        end
                    end else begin
                        // Timeout keeps running across STABLE -> WAIT_LOCK glitches.
                        tmo_d = tmo_q + TMO_W'(1);
                        if (state_q == ST_WAIT_LOCK) begin
                            if (lk) state_d = ST_STABLE;
                        end else if (!lk) begin
                            state_d = ST_WAIT_LOCK;
                        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                            state_d = ST_RELEASE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!lk) begin
                        state_d = ST_RESET;
                    end else if (stg_q == STG_W'(NUM_STAGES)) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == CNT_W'(STAGE_DELAY_CYCLES - 1)) begin
                        cnt_d = '0;
                        stg_d = stg_q + STG_W'(1);
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (stg_q == STG_W'(k)) rst_out_d[k] = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: if (!lk) state_d = ST_RESET;
                ST_FAULT: state_d = ST_FAULT;
                default: state_d = ST_IDLE;
            endcase
        end

        // Shared cycle counter and stage index start from zero in every state.
        if (state_d != state_q) begin
            cnt_d = '0;
            stg_d = '0;
        end

        case (state_d)
            ST_IDLE: begin
                pll_rst_d = 1'b1;
                pwrdwn_d  = 1'b1;
                rst_out_d = '0;
                retry_d   = '0;
            end
            ST_RESET: begin
                pll_rst_d = 1'b1;
                rst_out_d = '0;
            end
            ST_WAIT_LOCK, ST_STABLE: rst_out_d = '0;
            ST_RELEASE: ;
            ST_RUN: begin
                ready_d   = 1'b1;
                rst_out_d = '1;
                retry_d   = '0;
            end
            ST_FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
                rst_out_d = '0;
            end
            default: begin
                pll_rst_d = 1'b1;
                pwrdwn_d  = 1'b1;
                rst_out_d = '0;
            end
        endcase
    end

    // State, counters and outputs; synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            stg_q     <= '0;
            retry_q   <= '0;
            rst_out_q <= '0;
            pll_rst_q <= 1'b1;
            pwrdwn_q  <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            stg_q     <= stg_d;
            retry_q   <= retry_d;
            rst_out_q <= rst_out_d;
            pll_rst_q <= pll_rst_d;
            pwrdwn_q  <= pwrdwn_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign PLL_RST    = pll_rst_q;
    assign PLL_PWRDWN = pwrdwn_q;
    assign RST_OUT_N  = rst_out_q;
    assign READY      = ready_q;
    assign FAULT      = fault_q;
    assign RETRY_CNT  = retry_q;
    assign DBG_STATE  = state_q;

endmodule
